mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_ctrl_alu_dec.sv | 48 ++++
 rtl/mc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: ALU operation codes and the
// opcode/funct values it decodes.
package mc_ctrl_pkg;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU control decode for the execute states: R-type by Funct, I-type by Op.
// legal_o drops for an R-type Funct or I-type Op this datapath cannot execute.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Op_i,
  input  logic [5:0] Funct_i,
  output logic [3:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic       ext_op_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o    = ALU_NOP;
    alu_src_a_o = 2'd1;
    ext_op_o    = 1'b0;
    legal_o     = 1'b1;
    if (Op_i == OP_RTYPE) begin
      unique case (Funct_i)
        FN_ADD:  alu_op_o = ALU_ADD;
        FN_SUB:  alu_op_o = ALU_SUB;
        FN_AND:  alu_op_o = ALU_AND;
        FN_OR:   alu_op_o = ALU_OR;
        FN_XOR:  alu_op_o = ALU_XOR;
        FN_NOR:  alu_op_o = ALU_NOR;
        FN_SLT:  alu_op_o = ALU_SLT;
        FN_SLTU: alu_op_o = ALU_SLTU;
        // shifts take their A operand from the shamt field
        FN_SLL: begin alu_op_o = ALU_SLL; alu_src_a_o = 2'd2; end
        FN_SRL: begin alu_op_o = ALU_SRL; alu_src_a_o = 2'd2; end
        FN_SRA: begin alu_op_o = ALU_SRA; alu_src_a_o = 2'd2; end
        default: legal_o = 1'b0;
      endcase
    end else begin
      unique case (Op_i)
        OP_ADDI: begin alu_op_o = ALU_ADD; ext_op_o = 1'b1; end
        OP_SLTI: begin alu_op_o = ALU_SLT; ext_op_o = 1'b1; end
        OP_ANDI: alu_op_o = ALU_AND;
        OP_ORI:  alu_op_o = ALU_OR;
        OP_XORI: alu_op_o = ALU_XOR;
        OP_LUI:  alu_op_o = ALU_LUI;
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: Moore FSM over the IR fields, except the
// branch PC write which follows the current-cycle ALU Zero flag.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       EXTOp,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXE_R, S_EXE_I, S_ALUWB, S_BRANCH, S_JUMP, S_JR
  } state_e;

  state_e state_q, state_d;

  logic [3:0] dec_alu_op;
  logic [1:0] dec_src_a;
  logic       dec_ext_op;
  logic       dec_legal;

  // raw enables before reset gating
  logic pc_wr, mem_wr, ir_wr, reg_wr, ill;

  alu_dec u_alu_dec (
    .Op_i        (Op),
    .Funct_i     (Funct),
    .alu_op_o    (dec_alu_op),
    .alu_src_a_o (dec_src_a),
    .ext_op_o    (dec_ext_op),
    .legal_o     (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_wr    = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    ill      = 1'b0;
    IorD     = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ALUOp    = ALU_NOP;
    PCSource = 2'd0;
    EXTOp    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = ALU_ADD;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // speculative branch target lands in ALUOut
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        unique case (Op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = (Funct == FN_JR) ? S_JR : S_EXE_R;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_d = S_EXE_I;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J, OP_JAL:    state_d = S_JUMP;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        MemtoReg = 2'd1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD    = 1'b1;
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXE_R: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_src_a;
        if (dec_legal) state_d = S_ALUWB;
        else begin
          ill     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXE_I: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        EXTOp   = dec_ext_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = 1'b1;
        RegDst  = (Op == OP_RTYPE) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'd1;
        ALUOp    = ALU_SUB;
        PCSource = 2'd1;
        // Op[0] separates bne from beq
        pc_wr    = Op[0] ? ~Zero : Zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_wr    = 1'b1;
        PCSource = 2'd2;
        if (Op == OP_JAL) begin
          reg_wr   = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_wr    = 1'b1;
        PCSource = 2'd3;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // no architectural write may escape during a reset cycle
  assign PCWrite  = pc_wr  & ~rst;
  assign MemWrite = mem_wr & ~rst;
  assign IRWrite  = ir_wr  & ~rst;
  assign RegWrite = reg_wr & ~rst;
  assign Illegal  = ill    & ~rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Random instruction stream against an instruction-level model of the
// controller's per-cycle outputs, including mid-instruction resets.
module tb_mc_ctrl;

  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                         A_OR = 4'd4, A_XOR = 4'd5, A_NOR = 4'd6, A_SLT = 4'd7,
                         A_SLTU = 4'd8, A_SLL = 4'd9, A_SRL = 4'd10, A_SRA = 4'd11,
                         A_LUI = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, EXTOp, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;

  int checks = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .EXTOp(EXTOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,EXTOp,Illegal}
  logic [20:0] got;
  assign got = {PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, Illegal};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle k of instruction (op,fn); last marks its final cycle.
  function automatic logic [20:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic z, input logic r, input int k,
                                        output bit last);
    logic pcw = 0, iord = 0, mw = 0, irw = 0, rw = 0, ext = 0, ill = 0;
    logic [1:0] rd = 0, mtr = 0, sa = 0, sb = 0, ps = 0;
    logic [3:0] aop = A_NOP;
    bit lw  = (op == 6'h23);
    bit sw  = (op == 6'h2b);
    bit rt  = (op == 6'h00);
    bit jr  = rt && (fn == 6'h08);
    bit it  = (op == 6'h08 || op == 6'h0a || op == 6'h0c || op == 6'h0d ||
               op == 6'h0e || op == 6'h0f);
    bit br  = (op == 6'h04 || op == 6'h05);
    bit jmp = (op == 6'h02 || op == 6'h03);
    last = 0;
    if (k == 0) begin
      irw = 1; pcw = 1; sb = 1; aop = A_ADD;
    end else if (k == 1) begin
      sb = 3; ext = 1; aop = A_ADD;
      if (!(lw || sw || rt || it || br || jmp)) begin ill = 1; last = 1; end
    end else if (lw || sw) begin
      if (k == 2) begin sa = 1; sb = 2; ext = 1; aop = A_ADD; end
      else if (sw) begin iord = 1; mw = 1; last = 1; end
      else if (k == 3) iord = 1;
      else begin rw = 1; mtr = 1; last = 1; end
    end else if (jr) begin
      pcw = 1; ps = 3; last = 1;
    end else if (rt && k == 2) begin
      sa = 1;
      case (fn)
        6'h20: aop = A_ADD;  6'h22: aop = A_SUB;  6'h24: aop = A_AND;
        6'h25: aop = A_OR;   6'h26: aop = A_XOR;  6'h27: aop = A_NOR;
        6'h2a: aop = A_SLT;  6'h2b: aop = A_SLTU;
        6'h00: begin aop = A_SLL; sa = 2; end
        6'h02: begin aop = A_SRL; sa = 2; end
        6'h03: begin aop = A_SRA; sa = 2; end
        default: begin ill = 1; last = 1; end
      endcase
    end else if (it && k == 2) begin
      sa = 1; sb = 2;
      case (op)
        6'h08: begin aop = A_ADD; ext = 1; end
        6'h0a: begin aop = A_SLT; ext = 1; end
        6'h0c: aop = A_AND;
        6'h0d: aop = A_OR;
        6'h0e: aop = A_XOR;
        default: aop = A_LUI;
      endcase
    end else if (rt || it) begin
      rw = 1; rd = rt ? 2'd1 : 2'd0; last = 1;
    end else if (br) begin
      sa = 1; aop = A_SUB; ps = 1; pcw = op[0] ? ~z : z; last = 1;
    end else begin
      pcw = 1; ps = 2; last = 1;
      if (op == 6'h03) begin rw = 1; rd = 2; mtr = 2; end
    end
    if (r) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
    return {pcw, iord, mw, irw, rw, rd, mtr, sa, sb, aop, ps, ext, ill};
  endfunction

  // Runs one instruction from its FETCH cycle; rst_at>=0 pulses reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int rst_at, input string tag);
    bit last;
    bit was_rst;
    logic [20:0] exp;
    Op = op; Funct = fn;
    for (int k = 0; k < 8; k++) begin
      Zero = 1'($urandom);
      rst  = (k == rst_at);
      exp  = model(op, fn, Zero, rst, k, last);
      @(negedge clk);
      chk(tag, 32'(got), 32'(exp));
      @(posedge clk); #1;
      was_rst = rst;
      rst = 1'b0;
      if (was_rst || last) return;
    end
    chk({tag, "_len"}, 32'd0, 32'd1);
  endtask

  logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                           6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f};
  logic [5:0] fns [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                           6'h00, 6'h02, 6'h03, 6'h08};

  initial begin
    logic [5:0] op, fn;
    int ra;
    rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_we", {27'd0, PCWrite, MemWrite, IRWrite, RegWrite, Illegal}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    run_instr(6'h23, 6'h00, -1, "lw");
    run_instr(6'h2b, 6'h00, -1, "sw");
    run_instr(6'h04, 6'h00, -1, "beq");
    run_instr(6'h05, 6'h00, -1, "bne");
    run_instr(6'h00, 6'h00, -1, "sll");
    run_instr(6'h0d, 6'h00, -1, "ori");
    run_instr(6'h0f, 6'h00, -1, "lui");
    run_instr(6'h03, 6'h00, -1, "jal");
    run_instr(6'h00, 6'h08, -1, "jr");
    run_instr(6'h3f, 6'h00, -1, "ill_op");
    run_instr(6'h00, 6'h3f, -1, "ill_fn");
    run_instr(6'h23, 6'h00, 3, "lw_rst_memrd");
    run_instr(6'h03, 6'h00, 2, "jal_rst");
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, ra, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
